// File: rtl/i2c_reg_access_ctrl.sv
// Register read/write sequencer for i2c_master: expands one request into the
// I2C command sequence and reports read data and slave NACK.
module i2c_reg_access_ctrl #(
   parameter int unsigned REG_ADDR_BYTES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic [6:0]  req_dev_addr,
   input  logic [15:0] req_reg_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_nack,
   output logic [2:0]  m_cmd,
   output logic [7:0]  m_din,
   output logic        m_wr_i2c,
   input  logic        m_ready,
   input  logic        m_done_tick,
   input  logic        m_ack,
   input  logic [7:0]  m_dout
);

   localparam int unsigned STEP_W = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_GUARD = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [2:0] CMD_START   = 3'b000;
   localparam logic [2:0] CMD_WR      = 3'b001;
   localparam logic [2:0] CMD_RD      = 3'b010;
   localparam logic [2:0] CMD_STOP    = 3'b011;
   localparam logic [2:0] CMD_RESTART = 3'b100;

   logic [2:0]        state, state_n;
   logic [STEP_W-1:0] step, step_n;
   logic              ack_err, ack_err_n;
   logic [7:0]        rd_byte, rd_byte_n;
   logic              done_seen, done_seen_n;
   logic              req_ready_n, rsp_valid_n, rsp_nack_n, m_wr_i2c_n;
   logic [7:0]        rsp_rdata_n, m_din_n;
   logic [2:0]        m_cmd_n;

   logic              rnw_q;
   logic [6:0]        dev_q;
   logic [15:0]       reg_q;
   logic [7:0]        wdata_q;

   logic              accept;
   logic [STEP_W-1:0] eff_step;
   logic [2:0]        step_cmd;
   logic [7:0]        step_din;
   logic              is_byte;

   assign accept  = (state == S_IDLE) && req_ready && req_valid;
   assign is_byte = (m_cmd == CMD_WR) || (m_cmd == CMD_RD);

   // Single-byte addressing skips the reg_hi slot of the common step table
   assign eff_step = step + (((REG_ADDR_BYTES == 32'd1) && (step >= STEP_W'(2)))
                             ? STEP_W'(1) : STEP_W'(0));

   // Step table: command and data byte for the current step
   always_comb begin
      step_cmd = CMD_STOP;
      step_din = 8'h00;
      case (eff_step)
         STEP_W'(0): step_cmd = CMD_START;
         STEP_W'(1): begin step_cmd = CMD_WR; step_din = {dev_q, 1'b0}; end
         STEP_W'(2): begin step_cmd = CMD_WR; step_din = reg_q[15:8]; end
         STEP_W'(3): begin step_cmd = CMD_WR; step_din = reg_q[7:0]; end
         STEP_W'(4): begin
            if (rnw_q) step_cmd = CMD_RESTART;
            else begin step_cmd = CMD_WR; step_din = wdata_q; end
         end
         STEP_W'(5): begin
            if (rnw_q) begin step_cmd = CMD_WR; step_din = {dev_q, 1'b1}; end
            else step_cmd = CMD_STOP;
         end
         STEP_W'(6): begin step_cmd = CMD_RD; step_din = 8'h01; end
         default: begin step_cmd = CMD_STOP; step_din = 8'h00; end
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      step_n      = step;
      ack_err_n   = ack_err;
      rd_byte_n   = rd_byte;
      done_seen_n = done_seen;
      req_ready_n = 1'b0;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      rsp_nack_n  = rsp_nack;
      m_cmd_n     = m_cmd;
      m_din_n     = m_din;
      m_wr_i2c_n  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready_n = 1'b1;
            if (accept) begin
               state_n     = S_ISSUE;
               req_ready_n = 1'b0;
               step_n      = '0;
               ack_err_n   = 1'b0;
               rd_byte_n   = 8'h00;
               done_seen_n = 1'b0;
            end
         end
         S_ISSUE: begin
            if (m_ready) begin
               // A NACK short-circuits the remaining steps straight to STOP
               m_cmd_n     = ack_err ? CMD_STOP : step_cmd;
               m_din_n     = ack_err ? 8'h00 : step_din;
               m_wr_i2c_n  = 1'b1;
               done_seen_n = 1'b0;
               state_n     = S_GUARD;
            end
         end
         S_GUARD: state_n = S_WAIT;
         S_WAIT: begin
            if (is_byte && m_done_tick) begin
               done_seen_n = 1'b1;
               if (m_cmd == CMD_WR) ack_err_n = ack_err | m_ack;
               else                 rd_byte_n = m_dout;
            end
            if (m_ready && (!is_byte || done_seen || m_done_tick)) begin
               if (m_cmd == CMD_STOP) begin
                  state_n     = S_RESP;
                  rsp_valid_n = 1'b1;
                  rsp_nack_n  = ack_err_n;
                  rsp_rdata_n = (rnw_q && !ack_err_n) ? rd_byte_n : 8'h00;
               end else begin
                  step_n  = step + STEP_W'(1);
                  state_n = S_ISSUE;
               end
            end
         end
         S_RESP: begin
            state_n     = S_IDLE;
            req_ready_n = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         step      <= '0;
         ack_err   <= 1'b0;
         rd_byte   <= 8'h00;
         done_seen <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_nack  <= 1'b0;
         m_cmd     <= CMD_START;
         m_din     <= 8'h00;
         m_wr_i2c  <= 1'b0;
      end else begin
         state     <= state_n;
         step      <= step_n;
         ack_err   <= ack_err_n;
         rd_byte   <= rd_byte_n;
         done_seen <= done_seen_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_nack  <= rsp_nack_n;
         m_cmd     <= m_cmd_n;
         m_din     <= m_din_n;
         m_wr_i2c  <= m_wr_i2c_n;
      end
   end

   // Request capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rnw_q   <= 1'b0;
         dev_q   <= 7'h00;
         reg_q   <= 16'h0000;
         wdata_q <= 8'h00;
      end else if (accept) begin
         rnw_q   <= req_rnw;
         dev_q   <= req_dev_addr;
         reg_q   <= req_reg_addr;
         wdata_q <= req_wdata;
      end
   end

endmodule
